// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipe elastic pipeline register.
// The merge helper works on a wide word so one function serves every WIDTH.
package dff_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 4;
   localparam int MAX_WIDTH = 256;

   typedef logic [MAX_WIDTH-1:0] wide_t;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Clear beats mask: a bit with clr=1 is zero whatever the mask says.
   function automatic wide_t merge_word(input wide_t data, input wide_t mask,
                                        input wide_t last, input wide_t clr);
      return ((data & mask) | (last & ~mask)) & ~clr;
   endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One valid/data flop pair of the pipeline chain.
// Flush drops the valid bit but leaves the data bits untouched.
module dff_pipe_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             load,
   input  logic             flush,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // NOTE: data is reset along with valid so no value from before reset can
   // ever reach out_data; sequential state is always written with <=.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= up_valid;
         if (up_valid) data <= up_data;
      end
   end

endmodule

// File: rtl/dff_pipe.sv
// Elastic DEPTH-stage pipeline register with masked/cleared capture,
// valid/ready handshake on both ends, flush and an occupancy count.
module dff_pipe
   import dff_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                      clk,
   input  logic                      nreset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [WIDTH-1:0]          in_mask,
   input  logic [WIDTH-1:0]          in_clr,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [cnt_w(DEPTH)-1:0]   count
);

   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] ready;
   logic [WIDTH-1:0] data [DEPTH];
   logic [WIDTH-1:0] last;
   logic [WIDTH-1:0] w;
   logic             accept;
   logic             emit;

   assign out_valid = valid[DEPTH-1] && !flush;
   assign out_data  = data[DEPTH-1];
   assign emit      = out_valid && out_ready;

   // A stage can take a word if it, or any stage downstream of it, has room
   // this cycle; this is the combinational path from out_ready back to stage 0.
   always_comb begin : ready_chain
      logic room;
      room  = out_ready && !flush;
      ready = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         room     = room || !valid[i];
         ready[i] = room;
      end
   end

   assign in_ready = nreset && !flush && ready[0];
   assign accept   = in_valid && in_ready;
   assign w        = WIDTH'(merge_word(wide_t'(in_data), wide_t'(in_mask),
                                       wide_t'(last), wide_t'(in_clr)));

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             up_valid;
      logic [WIDTH-1:0] up_data;

      if (i == 0) begin : g_head
         assign up_valid = accept;
         assign up_data  = w;
      end else begin : g_body
         assign up_valid = valid[i-1];
         assign up_data  = data[i-1];
      end

      dff_pipe_stage #(.WIDTH(WIDTH)) u_stage (
         .clk      (clk),
         .nreset   (nreset),
         .load     (ready[i]),
         .flush    (flush),
         .up_valid (up_valid),
         .up_data  (up_data),
         .valid    (valid[i]),
         .data     (data[i])
      );
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         last  <= '0;
         count <= '0;
      end else begin
         if (accept) last <= w;
         if (flush) begin
            count <= '0;
         end else begin
            case ({accept, emit})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: a DEPTH=4 instance for stream/stall/mask/
// flush/reset sequences and a DEPTH=1 instance for full push-and-pop.
module tb_dff_pipe;

   logic        clk = 1'b0;
   logic        nreset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [31:0] in_mask;
   logic [31:0] in_clr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  count;

   logic        d1_flush;
   logic        d1_in_valid;
   logic        d1_in_ready;
   logic [31:0] d1_in_data;
   logic [31:0] d1_in_mask;
   logic [31:0] d1_in_clr;
   logic        d1_out_valid;
   logic        d1_out_ready;
   logic [31:0] d1_out_data;
   logic [0:0]  d1_count;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   dff_pipe #(.WIDTH(32), .DEPTH(4)) dut (
      .clk       (clk),
      .nreset    (nreset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mask   (in_mask),
      .in_clr    (in_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   dff_pipe #(.WIDTH(32), .DEPTH(1)) dut1 (
      .clk       (clk),
      .nreset    (nreset),
      .flush     (d1_flush),
      .in_valid  (d1_in_valid),
      .in_ready  (d1_in_ready),
      .in_data   (d1_in_data),
      .in_mask   (d1_in_mask),
      .in_clr    (d1_in_clr),
      .out_valid (d1_out_valid),
      .out_ready (d1_out_ready),
      .out_data  (d1_out_data),
      .count     (d1_count)
   );

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        ov;
      logic [31:0] od;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one word and hold it until accepted, bounded by a cycle budget.
   task automatic push(input logic [31:0] d, input logic [31:0] m, input logic [31:0] c);
      int   cyc;
      logic ok;
      cyc = 0;
      ok  = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_mask  = m;
      in_clr   = c;
      while (!ok && cyc < 20) begin
         @(negedge clk);
         ok = in_ready;
         tick();
         cyc++;
      end
      if (!ok) check("push accept timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
   endtask

   // Collect emitted words and compare them in order against exp_q.
   task automatic drain(input string name, input int budget);
      int cyc;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < budget) begin
         @(negedge clk);
         if (out_valid && out_ready) check(name, out_data, exp_q.pop_front());
         tick();
         cyc++;
      end
      if (exp_q.size() != 0) begin
         check({name, " words left at timeout"}, 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b1, 32'd0, 1'b0, 32'd0, 3'd0};
      vecs[1]  = '{1'b1, 32'd1, 1'b0, 32'd0, 3'd1};
      vecs[2]  = '{1'b1, 32'd2, 1'b0, 32'd0, 3'd2};
      vecs[3]  = '{1'b1, 32'd3, 1'b0, 32'd0, 3'd3};
      vecs[4]  = '{1'b1, 32'd4, 1'b1, 32'd0, 3'd4};
      vecs[5]  = '{1'b1, 32'd5, 1'b1, 32'd1, 3'd4};
      vecs[6]  = '{1'b1, 32'd6, 1'b1, 32'd2, 3'd4};
      vecs[7]  = '{1'b1, 32'd7, 1'b1, 32'd3, 3'd4};
      vecs[8]  = '{1'b0, 32'd0, 1'b1, 32'd4, 3'd4};
      vecs[9]  = '{1'b0, 32'd0, 1'b1, 32'd5, 3'd3};
      vecs[10] = '{1'b0, 32'd0, 1'b1, 32'd6, 3'd2};
      vecs[11] = '{1'b0, 32'd0, 1'b1, 32'd7, 3'd1};
      vecs[12] = '{1'b0, 32'd0, 1'b0, 32'd7, 3'd0};

      nreset       = 1'b0;
      flush        = 1'b0;
      in_valid     = 1'b0;
      in_data      = '0;
      in_mask      = '1;
      in_clr       = '0;
      out_ready    = 1'b1;
      d1_flush     = 1'b0;
      d1_in_valid  = 1'b0;
      d1_in_data   = '0;
      d1_in_mask   = '1;
      d1_in_clr    = '0;
      d1_out_ready = 1'b1;

      // Reset state
      #12;
      check("reset in_ready", 32'(in_ready), 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_data", out_data, 32'd0);
      check("reset count", 32'(count), 32'd0);
      nreset = 1'b1;
      tick();

      // Stream 0..7 with out_ready held high
      for (int c = 0; c < 13; c++) begin
         in_valid = vecs[c].iv;
         in_data  = vecs[c].d;
         @(negedge clk);
         check($sformatf("stream[%0d] in_ready", c), 32'(in_ready), 32'd1);
         check($sformatf("stream[%0d] out_valid", c), 32'(out_valid), 32'(vecs[c].ov));
         check($sformatf("stream[%0d] out_data", c), out_data, vecs[c].od);
         check($sformatf("stream[%0d] count", c), 32'(count), 32'(vecs[c].cnt));
         tick();
      end

      // Stall: five words offered, four fit
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_data = 32'hA0 + 32'(k);
         @(negedge clk);
         check($sformatf("stall accept %0d", k), 32'(in_ready), 32'd1);
         tick();
      end
      in_data = 32'hA4;
      @(negedge clk);
      check("stall full in_ready", 32'(in_ready), 32'd0);
      check("stall full count", 32'(count), 32'd4);
      check("stall out_valid", 32'(out_valid), 32'd1);
      check("stall out_data", out_data, 32'hA0);
      tick();
      check("stall out_data held", out_data, 32'hA0);
      out_ready = 1'b1;
      #1;
      check("stall in_ready same cycle", 32'(in_ready), 32'd1);
      check("stall drain word 0", out_data, 32'hA0);
      tick();
      in_valid = 1'b0;
      for (int k = 1; k < 5; k++) exp_q.push_back(32'hA0 + 32'(k));
      drain("stall drain", 20);
      @(negedge clk);
      check("stall empty count", 32'(count), 32'd0);
      check("stall empty out_valid", 32'(out_valid), 32'd0);
      tick();

      // Mask and clear merging
      push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
      push(32'h0000_0000, 32'hFFFF_0000, 32'h0);
      push(32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_00FF);
      in_clr = '0;
      exp_q.push_back(32'hFFFF_FFFF);
      exp_q.push_back(32'h0000_FFFF);
      exp_q.push_back(32'h1234_5600);
      drain("mask out", 20);

      // Flush with three valid stages and a word on offer
      out_ready = 1'b0;
      push(32'hB0, 32'hFFFF_FFFF, 32'h0);
      push(32'hB1, 32'hFFFF_FFFF, 32'h0);
      push(32'hB2, 32'hFFFF_FFFF, 32'h0);
      tick();
      @(negedge clk);
      check("preflush count", 32'(count), 32'd3);
      check("preflush out_valid", 32'(out_valid), 32'd1);
      check("preflush out_data", out_data, 32'hB0);
      tick();
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hC0FF_EE00;
      in_mask  = '1;
      @(negedge clk);
      check("flush in_ready", 32'(in_ready), 32'd0);
      check("flush out_valid", 32'(out_valid), 32'd0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("postflush count", 32'(count), 32'd0);
      check("postflush out_valid", 32'(out_valid), 32'd0);
      tick();
      push(32'h0, 32'h0, 32'h0);
      @(negedge clk);
      check("postflush push count", 32'(count), 32'd1);
      tick();
      out_ready = 1'b1;
      exp_q.push_back(32'hB2);
      drain("flush last merge", 20);
      @(negedge clk);
      check("flush nothing extra", 32'(out_valid), 32'd0);
      tick();

      // Asynchronous reset mid-stream
      push(32'hD0, 32'hFFFF_FFFF, 32'h0);
      push(32'hD1, 32'hFFFF_FFFF, 32'h0);
      push(32'hD2, 32'hFFFF_FFFF, 32'h0);
      push(32'hD3, 32'hFFFF_FFFF, 32'h0);
      #1;
      check("prereset out_data", out_data, 32'hD0);
      nreset = 1'b0;
      #1;
      check("async reset out_valid", 32'(out_valid), 32'd0);
      check("async reset out_data", out_data, 32'd0);
      check("async reset count", 32'(count), 32'd0);
      check("async reset in_ready", 32'(in_ready), 32'd0);
      #1;
      nreset = 1'b1;
      tick();
      push(32'hFFFF_FFFF, 32'h0, 32'h0);
      exp_q.push_back(32'h0);
      drain("reset last cleared", 20);

      // DEPTH = 1: full register with push and pop every cycle
      d1_out_ready = 1'b0;
      d1_in_valid  = 1'b1;
      d1_in_data   = 32'hE0;
      @(negedge clk);
      check("d1 empty in_ready", 32'(d1_in_ready), 32'd1);
      tick();
      @(negedge clk);
      check("d1 full in_ready", 32'(d1_in_ready), 32'd0);
      check("d1 full count", 32'(d1_count), 32'd1);
      check("d1 full out_data", d1_out_data, 32'hE0);
      tick();
      d1_out_ready = 1'b1;
      #1;
      check("d1 in_ready same cycle", 32'(d1_in_ready), 32'd1);
      for (int k = 1; k < 7; k++) begin
         d1_in_data = 32'hE0 + 32'(k);
         @(negedge clk);
         check($sformatf("d1 stream[%0d] out_valid", k), 32'(d1_out_valid), 32'd1);
         check($sformatf("d1 stream[%0d] out_data", k), d1_out_data, 32'hE0 + 32'(k - 1));
         check($sformatf("d1 stream[%0d] count", k), 32'(d1_count), 32'd1);
         check($sformatf("d1 stream[%0d] in_ready", k), 32'(d1_in_ready), 32'd1);
         tick();
      end
      d1_in_valid = 1'b0;
      @(negedge clk);
      check("d1 last word", d1_out_data, 32'hE6);
      tick();
      @(negedge clk);
      check("d1 empty out_valid", 32'(d1_out_valid), 32'd0);
      check("d1 empty count", 32'(d1_count), 32'd0);
      check("d1 empty out_data held", d1_out_data, 32'hE6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
